ifu: RTL and testbench
======================

IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, is the first fetch address after reset.
REQ-002 Parameter WAIT_MAX, default 16, is the maximum number of cycles a fetch may wait for imem_ack.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 npc_sel  in  2  next-PC select: 0 = sequential, 1 = branch, 2 = jump, 3 = reserved (treated as sequential).
REQ-006 imm32  in  32  extended immediate from the immediate extender; branch offset in words.
REQ-007 target26  in  26  jump target field of the current instruction.
REQ-008 advance  in  1  datapath has retired the current instruction; sampled only in HOLD.
REQ-009 imem_req  out  1  fetch request to instruction memory.
REQ-010 imem_addr  out  32  fetch address; equals pc whenever imem_req=1.
REQ-011 imem_ack  in  1  memory returns imem_rdata this cycle.
REQ-012 imem_rdata  in  32  fetched instruction word.
REQ-013 instr  out  32  registered current instruction.
REQ-014 instr_valid  out  1  instr is valid and held for the datapath.
REQ-015 imm16  out  16  instr[15:0], feeding the immediate extender.
REQ-016 pc  out  32  address of the current or pending instruction.
REQ-017 fetch_err  out  1  sticky fetch-timeout flag.

Function
REQ-018 The FSM SHALL have the states IDLE, FETCH, HOLD and ERR, with IDLE as the reset state.
REQ-019 IDLE SHALL go to FETCH on the first clock edge after rst_n deasserts.
REQ-020 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc.
REQ-021 On imem_ack in FETCH, instr SHALL capture imem_rdata, the state SHALL go to HOLD, and the next cycle SHALL show instr_valid=1 and imem_req=0 (one-cycle latency from ack).
REQ-022 In HOLD, instr_valid SHALL be 1, and instr, imm16 and pc SHALL remain stable until advance=1.
REQ-023 On advance in HOLD, pc SHALL load the next PC, instr_valid SHALL drop, and the state SHALL go to FETCH.
REQ-024 The next PC SHALL be computed as follows, with all arithmetic modulo 2^32:
- sequential: pc+4;
- branch: pc+4+(imm32<<2);
- jump: {pc_plus4[31:28], target26, 2'b00}.
REQ-025 pc wrap-around SHALL be silent: 32'hFFFF_FFFC sequential SHALL give 32'h0000_0000.
REQ-026 imem_addr[1:0] SHALL always be 2'b00; the low bits of any computed next PC SHALL be forced to zero.
REQ-027 advance SHALL be ignored in IDLE, FETCH and ERR.
REQ-028 imem_ack SHALL be ignored outside FETCH.
REQ-029 A wait counter SHALL clear on entry to FETCH and increment each FETCH cycle without ack.
REQ-030 When the wait counter reaches WAIT_MAX, the block SHALL go to ERR and set fetch_err=1.
REQ-031 An ack arriving in the same cycle the counter reaches WAIT_MAX SHALL win: the instruction is accepted and no error is raised.
REQ-032 ERR SHALL hold imem_req=0 and instr_valid=0 with fetch_err=1, and SHALL be left only by reset.

Reset
REQ-033 While rst_n=0, the outputs SHALL be forced immediately:
- pc = RESET_PC;
- instr = 0, instr_valid = 0;
- imem_req = 0, fetch_err = 0;
- wait counter = 0, state = IDLE.
REQ-034 Reset asserted mid-fetch SHALL drop imem_req asynchronously, and a late imem_ack after reset SHALL be ignored.

Structure
REQ-035 The shared package mips_pkg SHALL hold the NPC_SEQ/NPC_BRANCH/NPC_JUMP encodings, the RESET_PC default and the FSM state encoding.
REQ-036 The next-PC calculation SHALL be a combinational sub-module named npc, instantiated once inside ifu.

Verification
REQ-037 Reset then fetch:
- stimulus: release rst_n; ack on the 2nd FETCH cycle with imem_rdata=32'h1234_5678;
- required: imem_addr=32'h3000 while requesting; instr=32'h1234_5678, imm16=16'h5678 and instr_valid=1 one cycle after ack.
REQ-038 Sequential and branch advance:
- stimulus: in HOLD at pc=32'h3000, advance with npc_sel=0;
- required: next imem_addr=32'h3004;
- stimulus: then npc_sel=1, imm32=32'hFFFF_FFFF;
- required: next pc=32'h3004.
REQ-039 Jump:
- stimulus: pc=32'h3008, npc_sel=2, target26=26'h000_0C10, advance;
- required: pc=32'h0000_3040.
REQ-040 Timeout:
- stimulus: no ack for 16 FETCH cycles;
- required: fetch_err=1, imem_req=0, and the block stays in ERR until rst_n=0.
REQ-041 Ack on the boundary cycle:
- stimulus: ack exactly on the 16th wait cycle;
- required: instruction accepted, fetch_err=0.
REQ-042 Reset mid-fetch and wrap-around:
- stimulus: assert rst_n=0 during FETCH;
- required: imem_req=0 in the same cycle, pc=32'h3000;
- stimulus: sequential advance at pc=32'hFFFF_FFFC;
- required: imem_addr=32'h0.

Source files
------------

// File: rtl/mips_pkg.sv
// +----------------------------------------------------------------------------+
// | mips_pkg : shared encodings for the instruction fetch unit                 |
// | Rev 1.0  : initial release                                                 |
// +----------------------------------------------------------------------------+
`default_nettype none

package mips_pkg;

  localparam logic [1:0]  NPC_SEQ    = 2'd0;
  localparam logic [1:0]  NPC_BRANCH = 2'd1;
  localparam logic [1:0]  NPC_JUMP   = 2'd2;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_ERR   = 2'd3
  } ifu_state_e;

endpackage

`default_nettype wire

// File: rtl/npc.sv
// +----------------------------------------------------------------------------+
// | npc : combinational next-PC calculation (sequential / branch / jump)       |
// | Rev 1.0  : initial release                                                 |
// +----------------------------------------------------------------------------+
`default_nettype none

module npc
  import mips_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [1:0]  npc_sel_i,
  input  logic [31:0] imm32_i,
  input  logic [25:0] target26_i,
  output logic [31:0] npc_o
);

  logic [31:0] pc_plus4;
  logic [31:0] raw_npc;

  assign pc_plus4 = pc_i + 32'd4;

  always_comb begin
    raw_npc = pc_plus4;
    case (npc_sel_i)
      NPC_BRANCH: raw_npc = pc_plus4 + (imm32_i << 2);
      NPC_JUMP:   raw_npc = {pc_plus4[31:28], target26_i, 2'b00};
      default:    raw_npc = pc_plus4;
    endcase
  end

  // Fetch addresses are always word aligned.
  assign npc_o = {raw_npc[31:2], 2'b00};

endmodule

`default_nettype wire

// File: rtl/ifu.sv
// +----------------------------------------------------------------------------+
// | ifu : instruction fetch unit with bounded memory wait and sticky timeout   |
// | Rev 1.0  : initial release                                                 |
// +----------------------------------------------------------------------------+
`default_nettype none

module ifu
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned WAIT_MAX = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  npc_sel,
  input  logic [31:0] imm32,
  input  logic [25:0] target26,
  input  logic        advance,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [15:0] imm16,
  output logic [31:0] pc,
  output logic        fetch_err
);

  localparam int unsigned WAIT_W = $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

  ifu_state_e        state_q;
  logic [31:0]       pc_q;
  logic [31:0]       instr_q;
  logic              valid_q;
  logic              req_q;
  logic              err_q;
  logic [WAIT_W-1:0] wait_q;
  logic [31:0]       npc_d;

  npc u_npc (
    .pc_i       (pc_q),
    .npc_sel_i  (npc_sel),
    .imm32_i    (imm32),
    .target26_i (target26),
    .npc_o      (npc_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
      wait_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_FETCH;
          req_q   <= 1'b1;
          wait_q  <= '0;
        end
        ST_FETCH: begin
          // An ack on the last permitted wait cycle takes priority over the timeout.
          if (imem_ack) begin
            instr_q <= imem_rdata;
            valid_q <= 1'b1;
            req_q   <= 1'b0;
            state_q <= ST_HOLD;
          end else if (wait_q == WAIT_LAST) begin
            wait_q  <= wait_q + 1'b1;
            req_q   <= 1'b0;
            err_q   <= 1'b1;
            state_q <= ST_ERR;
          end else begin
            wait_q  <= wait_q + 1'b1;
          end
        end
        ST_HOLD: begin
          if (advance) begin
            pc_q    <= npc_d;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            wait_q  <= '0;
            state_q <= ST_FETCH;
          end
        end
        default: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
          err_q   <= 1'b1;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign imm16       = instr_q[15:0];
  assign fetch_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_ifu.sv
// +----------------------------------------------------------------------------+
// | tb_ifu : directed self-checking bench for the instruction fetch unit       |
// | Rev 1.0  : initial release                                                 |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_ifu;

  logic        clk;
  logic        rst_n;
  logic [1:0]  npc_sel;
  logic [31:0] imm32;
  logic [25:0] target26;
  logic        advance;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [15:0] imm16;
  logic [31:0] pc;
  logic        fetch_err;

  int n_checks = 0;
  int n_errors = 0;

  ifu dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .npc_sel     (npc_sel),
    .imm32       (imm32),
    .target26    (target26),
    .advance     (advance),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .imm16       (imm16),
    .pc          (pc),
    .fetch_err   (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ack in the current FETCH cycle; returns just after the edge, in HOLD.
  task automatic do_fetch(input logic [31:0] data);
    imem_ack   = 1'b1;
    imem_rdata = data;
    tick();
    imem_ack   = 1'b0;
  endtask

  task automatic do_advance(input logic [1:0] sel, input logic [31:0] imm, input logic [25:0] tgt);
    npc_sel  = sel;
    imm32    = imm;
    target26 = tgt;
    advance  = 1'b1;
    tick();
    advance  = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    npc_sel    = 2'd0;
    imm32      = 32'd0;
    target26   = 26'd0;
    advance    = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    repeat (2) tick();

    check("rst_pc",    pc,          32'h0000_3000);
    check("rst_instr", instr,       32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_req",   {31'd0, imem_req},    32'd0);
    check("rst_err",   {31'd0, fetch_err},   32'd0);

    // Reset then fetch, ack on the second FETCH cycle; advance is ignored in FETCH.
    rst_n = 1'b1;
    tick();
    check("f1_req",  {31'd0, imem_req}, 32'd1);
    check("f1_addr", imem_addr,         32'h0000_3000);
    advance = 1'b1;
    tick();
    check("f2_req", {31'd0, imem_req}, 32'd1);
    do_fetch(32'h1234_5678);
    advance = 1'b0;
    check("ack_instr", instr,                32'h1234_5678);
    check("ack_imm16", {16'd0, imm16},       32'h0000_5678);
    check("ack_valid", {31'd0, instr_valid}, 32'd1);
    check("ack_req",   {31'd0, imem_req},    32'd0);
    check("ack_pc",    pc,                   32'h0000_3000);

    // Ack outside FETCH must not disturb the held instruction.
    do_fetch(32'hDEAD_BEEF);
    check("hold_instr", instr,                32'h1234_5678);
    check("hold_valid", {31'd0, instr_valid}, 32'd1);

    do_advance(2'd0, 32'd0, 26'd0);
    check("seq_addr",  imem_addr,            32'h0000_3004);
    check("seq_req",   {31'd0, imem_req},    32'd1);
    check("seq_valid", {31'd0, instr_valid}, 32'd0);

    do_fetch(32'h1000_FFFF);
    do_advance(2'd1, 32'hFFFF_FFFF, 26'd0);
    check("br_neg_pc", pc, 32'h0000_3004);

    do_fetch(32'h0000_0001);
    do_advance(2'd0, 32'd0, 26'd0);
    check("seq2_pc", pc, 32'h0000_3008);

    do_fetch(32'h0800_0C10);
    do_advance(2'd2, 32'd0, 26'h000_0C10);
    check("jump_pc",   pc,        32'h0000_3040);
    check("jump_addr", imem_addr, 32'h0000_3040);

    // Reserved select behaves as sequential.
    do_fetch(32'h0000_0002);
    do_advance(2'd3, 32'h0000_0100, 26'h3FF_FFFF);
    check("rsv_pc", pc, 32'h0000_3044);

    // Branch to the top word: 0x3048 + 0xFFFFCFB4 = 0xFFFFFFFC.
    do_fetch(32'h0000_0003);
    do_advance(2'd1, 32'h3FFF_F3ED, 26'd0);
    check("br_top_pc", pc, 32'hFFFF_FFFC);

    do_fetch(32'h0000_0004);
    do_advance(2'd0, 32'd0, 26'd0);
    check("wrap_addr", imem_addr, 32'h0000_0000);
    check("wrap_req",  {31'd0, imem_req}, 32'd1);

    // Reset mid-fetch drops the request without waiting for a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_req", {31'd0, imem_req}, 32'd0);
    check("arst_pc",  pc,                32'h0000_3000);
    imem_ack   = 1'b1;
    imem_rdata = 32'hAAAA_5555;
    tick();
    rst_n = 1'b1;
    tick();
    imem_ack = 1'b0;
    check("late_ack_valid", {31'd0, instr_valid}, 32'd0);
    check("late_ack_instr", instr,                32'd0);
    check("late_ack_req",   {31'd0, imem_req},    32'd1);

    // Timeout: now in FETCH cycle 1; sixteen cycles without ack.
    repeat (15) tick();
    check("to_c16_err", {31'd0, fetch_err}, 32'd0);
    check("to_c16_req", {31'd0, imem_req},  32'd1);
    tick();
    check("to_err",   {31'd0, fetch_err},   32'd1);
    check("to_req",   {31'd0, imem_req},    32'd0);
    check("to_valid", {31'd0, instr_valid}, 32'd0);
    advance    = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'h5555_AAAA;
    repeat (3) tick();
    advance  = 1'b0;
    imem_ack = 1'b0;
    check("err_stay_err",   {31'd0, fetch_err},   32'd1);
    check("err_stay_req",   {31'd0, imem_req},    32'd0);
    check("err_stay_valid", {31'd0, instr_valid}, 32'd0);

    rst_n = 1'b0;
    #1;
    check("err_clr", {31'd0, fetch_err}, 32'd0);

    // Ack arrives on the 16th wait cycle and wins over the timeout.
    tick();
    rst_n = 1'b1;
    tick();
    repeat (15) tick();
    do_fetch(32'hCAFE_F00D);
    check("bnd_valid", {31'd0, instr_valid}, 32'd1);
    check("bnd_instr", instr,                32'hCAFE_F00D);
    check("bnd_err",   {31'd0, fetch_err},   32'd0);
    repeat (3) tick();
    check("bnd_err_late", {31'd0, fetch_err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
